sdpram_bw_pipe: RTL and testbench

- Parametrised simple dual-port RAM: port A write-only, port B read-only, one shared clock.
- Generalises the fixed 64x32 registered SDPRAM to configurable width, depth and read latency.
- Adds per-byte write enables, a selectable same-address collision policy, a read-valid strobe and out-of-range protection.
- Memory is inferred, not a vendor macro.
- Sits between producer/consumer datapaths as a scratch buffer.

---
 rtl/sdpram_bw_pipe.sv | 107 ++++++++++
 tb/tb_sdpram_bw_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_bw_pipe.sv
// Simple dual-port RAM (write port A, read port B) with per-byte write enables,
// a configurable read pipeline, read-valid strobe and out-of-range protection.
module sdpram_bw_pipe #(
    parameter int DATA_W        = 32,
    parameter int BYTE_W        = 8,
    parameter int ADDR_W        = 6,
    parameter int DEPTH         = 64,
    parameter int READ_LATENCY  = 2,
    parameter int COLLISION_FWD = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [DATA_W/BYTE_W-1:0]   wea,
    input  logic [ADDR_W-1:0]          addra,
    input  logic [DATA_W-1:0]          dina,
    input  logic                       enb,
    input  logic [ADDR_W-1:0]          addrb,
    output logic [DATA_W-1:0]          doutb,
    output logic                       doutb_valid
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    generate
        if (DATA_W % BYTE_W != 0) begin : g_bad_width
            $error("sdpram_bw_pipe: DATA_W must be a multiple of BYTE_W");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("sdpram_bw_pipe: READ_LATENCY must be in 1..4");
        end
        if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("sdpram_bw_pipe: DEPTH must be in 2..2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign wr_in_range = ({1'b0, addra} < DEPTH_C);
    assign rd_in_range = ({1'b0, addrb} < DEPTH_C);
    assign wr_idx      = addra[IDX_W-1:0];
    assign rd_idx      = addrb[IDX_W-1:0];

    // Memory array is deliberately not reset so it maps onto RAM resources.
    always_ff @(posedge clk) begin
        if (ena && wr_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    mem[wr_idx][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // The array read sees pre-edge contents; forwarding overlays the lanes
    // being written on the same edge when new-data collision mode is chosen.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_idx];
            if (COLLISION_FWD != 0 && ena && (addra == addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wea[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    logic [DATA_W-1:0]       pipe_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_v;

    // Data stages load only behind a valid entry, so the last stage holds
    // its value through gaps and only the valid bit drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_d[k] <= '0;
            end
        end else begin
            pipe_v[0] <= enb;
            if (enb) begin
                pipe_d[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                if (pipe_v[k-1]) begin
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end
    end

    assign doutb       = pipe_d[READ_LATENCY-1];
    assign doutb_valid = pipe_v[READ_LATENCY-1];

endmodule

// File: tb/tb_sdpram_bw_pipe.sv
// Scoreboard bench for sdpram_bw_pipe: four instances with different depth,
// latency and collision settings share one directed stimulus stream.
module tb_sdpram_bw_pipe;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [3:0]  wea;
    logic [5:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [5:0]  addrb;
    logic [31:0] d_o [4];
    logic        v_o [4];

    exp_t        sb [4][$];
    logic [31:0] last [4];
    int          cyc;
    int          n_chk;
    int          n_pass;

    // dut0: DEPTH 48, RL 3, forward   dut1: DEPTH 64, RL 1, old data
    // dut2: DEPTH 64, RL 4, forward   dut3: DEPTH 64, RL 2, old data
    sdpram_bw_pipe #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .DEPTH(48),
                     .READ_LATENCY(3), .COLLISION_FWD(1)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(d_o[0]), .doutb_valid(v_o[0]));
    sdpram_bw_pipe #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .DEPTH(64),
                     .READ_LATENCY(1), .COLLISION_FWD(0)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(d_o[1]), .doutb_valid(v_o[1]));
    sdpram_bw_pipe #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .DEPTH(64),
                     .READ_LATENCY(4), .COLLISION_FWD(1)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(d_o[2]), .doutb_valid(v_o[2]));
    sdpram_bw_pipe #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .DEPTH(64),
                     .READ_LATENCY(2), .COLLISION_FWD(0)) dut3 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(d_o[3]), .doutb_valid(v_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        case (k)
            0: return 3;
            1: return 1;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    task automatic mon(input int k, input logic v, input logic [31:0] d);
        exp_t e;
        if (rst) return;
        if (v) begin
            n_chk++;
            if (sb[k].size() == 0) begin
                $display("FAIL unexpected_valid dut%0d cyc=%0d: got valid data=%h, required no valid", k, cyc, d);
            end else begin
                e = sb[k].pop_front();
                last[k] = e.data;
                if (d !== e.data || cyc != e.due)
                    $display("FAIL read dut%0d: got data=%h at cyc=%0d, required data=%h at cyc=%0d",
                             k, d, cyc, e.data, e.due);
                else
                    n_pass++;
            end
        end else begin
            if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                n_chk++;
                e = sb[k].pop_front();
                $display("FAIL missing_valid dut%0d cyc=%0d: got no valid, required data=%h at cyc=%0d",
                         k, cyc, e.data, e.due);
            end
            n_chk++;
            if (d !== last[k])
                $display("FAIL hold dut%0d cyc=%0d: got doutb=%h, required %h", k, cyc, d, last[k]);
            else
                n_pass++;
        end
    endtask

    always @(negedge clk) mon(0, v_o[0], d_o[0]);
    always @(negedge clk) mon(1, v_o[1], d_o[1]);
    always @(negedge clk) mon(2, v_o[2], d_o[2]);
    always @(negedge clk) mon(3, v_o[3], d_o[3]);

    task automatic drive(input logic e_a, input logic [3:0] w, input logic [5:0] aa,
                         input logic [31:0] di, input logic e_b, input logic [5:0] ab,
                         input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [31:0] x3);
        exp_t e;
        @(negedge clk);
        ena = e_a; wea = w; addra = aa; dina = di; enb = e_b; addrb = ab;
        if (e_b) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0: e.data = x0;
                    1: e.data = x1;
                    2: e.data = x2;
                    default: e.data = x3;
                endcase
                e.due = cyc + lat(k);
                sb[k].push_back(e);
            end
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] w);
        drive(1'b1, w, a, d, 1'b0, 6'd0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] x0, input logic [31:0] x1,
                      input logic [31:0] x2, input logic [31:0] x3);
        drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, a, x0, x1, x2, x3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
        else n_pass++;
    endtask

    initial begin
        logic [5:0]  a6;
        logic [31:0] x0;
        n_chk = 0; n_pass = 0;
        for (int k = 0; k < 4; k++) last[k] = 32'h0;
        rst = 1'b1; ena = 1'b0; wea = 4'h0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_doutb%0d", k), d_o[k], 32'h0);
            check($sformatf("reset_valid%0d", k), {31'h0, v_o[k]}, 32'h0);
        end
        rst = 1'b0;
        idle(2);

        // byte-enable merge
        wr(6'd10, 32'h11223344, 4'b1111);
        wr(6'd10, 32'hAABBCCDD, 4'b0101);
        rd(6'd10, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
        idle(6);

        // reset with reads in flight
        wr(6'd5, 32'hDEADBEEF, 4'b1111);
        rd(6'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        idle(1);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            last[k] = 32'h0;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("async_rst_doutb%0d", k), d_o[k], 32'h0);
            check($sformatf("async_rst_valid%0d", k), {31'h0, v_o[k]}, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);
        rd(6'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        idle(6);

        // streaming: fill then 64 back-to-back reads
        for (int i = 0; i < 64; i++) begin
            a6 = 6'(i);
            wr(a6, 32'(i), 4'b1111);
        end
        for (int i = 0; i < 64; i++) begin
            a6 = 6'(i);
            x0 = (i < 48) ? 32'(i) : 32'h0;
            rd(a6, x0, 32'(i), 32'(i), 32'(i));
        end
        idle(6);

        // out-of-range on the 48-deep instance
        wr(6'd50, 32'h12345678, 4'b1111);
        rd(6'd50, 32'h0, 32'h12345678, 32'h12345678, 32'h12345678);
        for (int i = 0; i < 48; i++) begin
            a6 = 6'(i);
            rd(a6, 32'(i), 32'(i), 32'(i), 32'(i));
        end
        idle(6);

        // same-edge collisions
        wr(6'd7, 32'h00000000, 4'b1111);
        drive(1'b1, 4'b1100, 6'd7, 32'hFFFF0000, 1'b1, 6'd7,
              32'hFFFF0000, 32'h00000000, 32'hFFFF0000, 32'h00000000);
        rd(6'd7, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000);
        wr(6'd8, 32'h01020304, 4'b1111);
        drive(1'b1, 4'b0011, 6'd8, 32'hAABBCCDD, 1'b1, 6'd8,
              32'h0102CCDD, 32'h01020304, 32'h0102CCDD, 32'h01020304);
        rd(6'd8, 32'h0102CCDD, 32'h0102CCDD, 32'h0102CCDD, 32'h0102CCDD);
        idle(6);

        // gapped reads: valid toggles, doutb holds through the gap
        wr(6'd1, 32'h0000000A, 4'b1111);
        wr(6'd2, 32'h0000000B, 4'b1111);
        rd(6'd1, 32'hA, 32'hA, 32'hA, 32'hA);
        idle(1);
        rd(6'd2, 32'hB, 32'hB, 32'hB, 32'hB);
        idle(8);

        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (sb[k].size() != 0)
                $display("FAIL drain dut%0d: got %0d outstanding reads, required 0", k, sb[k].size());
            else
                n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
